wb_cmd_master: RTL

- Wishbone pipelined-mode initiator: the bus-master counterpart to the LFSR Wishbone responder.
- Converts a simple command handshake (valid/ready) into single Wishbone read or write cycles.
- Returns read data, or a timeout error, as a one-cycle response pulse.
- Sits between test/control logic (or pin-driven sequencing in a TT top) and any Wishbone responder.

---
 rtl/wb_master_pkg.sv | 17 +
 rtl/wb_cmd_master_if.sv | 43 ++++
 rtl/wb_timeout_ctr.sv | 32 +++
 rtl/wb_cmd_master.sv | 118 +++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// Shared state type and default widths for the
// Wishbone command master and its helpers.
package wb_master_pkg;

  localparam int WB_AW      = 8;
  localparam int WB_DW      = 8;
  localparam int WB_TIMEOUT = 15;
  localparam int WB_CW      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command handshake plus Wishbone pipelined bus
// signals seen by the command master.
interface wb_cmd_master_if
  import wb_master_pkg::*;
#(
  parameter int AW = WB_AW,
  parameter int DW = WB_DW
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic          i_wb_stall;
  logic          i_wb_ack;
  logic [DW-1:0] i_wb_data;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    input  i_wb_stall, i_wb_ack, i_wb_data,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output o_wb_cyc, o_wb_stb, o_wb_we,
    output o_wb_addr, o_wb_data
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    output i_wb_stall, i_wb_ack, i_wb_data,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  o_wb_cyc, o_wb_stb, o_wb_we,
    input  o_wb_addr, o_wb_data
  );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts enabled cycles and
// flags the last allowed one at TIMEOUT-1.
module wb_timeout_ctr
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT = WB_TIMEOUT,
  parameter int CW      = WB_CW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && r_cnt != LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Turns valid/ready commands into single pipelined
// Wishbone cycles with a one-cycle response pulse.
module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = WB_TIMEOUT,
  parameter int CW      = WB_CW
) (
  input logic             clk,
  input logic             rst_n,
  wb_cmd_master_if.master bus
);

  wb_state_e     r_state;
  logic          r_cyc;
  logic          r_stb;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_rsp_valid;
  logic          r_rsp_err;

  logic w_idle;
  logic w_busy;
  logic w_resp;
  logic w_accept;
  logic w_ack;
  logic w_expire;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_resp   = (r_state == ST_RESP);
  assign w_busy   = (r_state == ST_REQ) ||
                    (r_state == ST_WAIT);
  assign w_accept = (r_state == ST_REQ) &&
                    !bus.i_wb_stall;
  // an ack during a stalled strobe is not ours
  assign w_ack    = bus.i_wb_ack &&
                    (w_accept || r_state == ST_WAIT);

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_idle),
    .i_enable (w_busy),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (1'b1)
        w_idle: begin
          if (bus.cmd_valid) begin
            r_we    <= bus.cmd_we;
            r_addr  <= bus.cmd_addr;
            r_wdata <= bus.cmd_wdata;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        w_busy: begin
          if (w_accept) r_stb <= 1'b0;
          // ack beats a simultaneous expiry
          if (w_ack) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            if (!r_we) r_rdata <= bus.i_wb_data;
            r_state     <= ST_RESP;
          end else if (w_expire) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= ST_RESP;
          end else if (w_accept) begin
            r_state <= ST_WAIT;
          end
        end
        w_resp: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = w_idle;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.o_wb_cyc  = r_cyc;
  assign bus.o_wb_stb  = r_stb;
  assign bus.o_wb_we   = r_we;
  assign bus.o_wb_addr = r_addr;
  assign bus.o_wb_data = r_wdata;

endmodule
